// File: rtl/fifo_level.sv
// fifo_level: synchronous FIFO for the audio path (codec interface -> filter
// datapath). Inferred dual-port RAM with one write port and one registered
// read port, occupancy count, almost-full/almost-empty thresholds,
// synchronous flush and sticky overflow/underflow error flags.
//
// Every status output is decoded from the registered occupancy count or comes
// straight from a register, so no combinational path runs from rd/wr to an
// output.

module fifo_level #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned AF_LEVEL   = 2**ADDR_WIDTH - 4,
    parameter int unsigned AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_valid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;

    // Thresholds sized to the count register so every comparison is same-width.
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);

    // Reject threshold settings that would make the flags meaningless.
    generate
        if (ADDR_WIDTH < 1) begin : g_bad_addr_width
            $error("fifo_level: ADDR_WIDTH must be at least 1");
        end
        if (!(AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
            $error("fifo_level: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] w_ptr_q,     w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q,     r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,     count_d;
    logic                  r_valid_q,   r_valid_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;
    logic [DATA_WIDTH-1:0] r_data_q;

    // ------------------------------------------------------------------
    // Status decode and accept rules (all from pre-edge registered state)
    // ------------------------------------------------------------------
    logic empty_s;
    logic full_s;
    logic wr_ok;
    logic rd_ok;
    logic push;
    logic pop;

    // Full/empty come from the count only; pointer equality is ambiguous.
    assign empty_s = (count_q == '0);
    assign full_s  = (count_q == DEPTH_C);

    // A write into a full FIFO is allowed only alongside an accepted read,
    // which is always the case when full because full implies non-empty.
    assign rd_ok = rd & ~empty_s;
    assign wr_ok = wr & (~full_s | rd);

    // Flush outranks traffic: nothing moves in a clear cycle.
    assign push = ~clear & wr_ok;
    assign pop  = ~clear & rd_ok;

    // ------------------------------------------------------------------
    // Next-state logic for pointers, count, strobe and error flags
    // ------------------------------------------------------------------
    // Compute next state for all control registers.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        r_valid_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (clear) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (push) begin
                w_ptr_d = w_ptr_q + PTR_ONE;
            end
            if (pop) begin
                r_ptr_d = r_ptr_q + PTR_ONE;
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            r_valid_d = pop;

            // Sticky errors: a dropped write or a read from an empty FIFO.
            if (wr && !wr_ok) begin
                overflow_d = 1'b1;
            end
            if (rd && empty_s) begin
                underflow_d = 1'b1;
            end
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            r_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            r_valid_q   <= r_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    // RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset so it maps onto block RAM; the count
        // guarantees no unwritten entry is ever popped.
        if (push) begin
            mem_q[w_ptr_q] <= w_data;
        end
    end

    // Registered read port; holds the last popped word when idle or flushed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_q <= '0;
        end else if (pop) begin
            r_data_q <= mem_q[r_ptr_q];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign r_data       = r_data_q;
    assign r_valid      = r_valid_q;
    assign count        = count_q;
    assign empty        = empty_s;
    assign full         = full_s;
    assign almost_empty = (count_q <= AE_C);
    assign almost_full  = (count_q >= AF_C);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: doc/fifo_level.md
Name: fifo_level

Overview:
Parameterised synchronous FIFO with occupancy count, programmable almost-full/almost-empty flags, registered read data with valid strobe, synchronous flush, and sticky overflow/underflow error flags. It is the generalised successor of the lab audio-path FIFO (24-bit samples by default). It buffers samples between the audio codec interface and the filter datapath. Depth is 2**ADDR_WIDTH entries; storage is an inferred dual-port RAM with one write port and one registered read port.

Parameters:
ADDR_WIDTH, 10, address bits; DEPTH = 2**ADDR_WIDTH entries
DATA_WIDTH, 24, bits per entry
AF_LEVEL, 2**ADDR_WIDTH-4, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush; empties FIFO, clears error flags
wr  in  1  write request
w_data  in  DATA_WIDTH  write data
rd  in  1  read request
r_data  out  DATA_WIDTH  read data, registered
r_valid  out  1  r_data holds a newly popped entry this cycle
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full and not accepted
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Reset (async, immediate): w_ptr=0, r_ptr=0, count=0, r_data=0, r_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0). RAM contents are not reset.
- Every flag is a registered function of count, or is derived combinationally from registered count. There is no combinational path from rd or wr to any output.
- Accept rules, evaluated each cycle from the pre-edge state:
  - wr_ok = wr & (~full | rd); a write is allowed when full only if a read is accepted in the same cycle.
  - rd_ok = rd & ~empty.
- Push (wr_ok): mem[w_ptr] <= w_data; w_ptr <= w_ptr+1, wrapping modulo DEPTH.
- Pop (rd_ok): r_data <= mem[r_ptr]; r_ptr <= r_ptr+1 (wrap). r_valid=1 in the following cycle only. Read latency is 1 clock from the accepted rd edge to r_data/r_valid.
- When no pop occurs, r_valid=0 and r_data holds its last value.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither. Width is ADDR_WIDTH+1, so DEPTH is representable.
- Simultaneous rd&wr:
  - Non-empty, non-full: both accepted; count unchanged.
  - Full: both accepted; the popped entry is the oldest; full stays 1.
  - Empty: write accepted, read rejected; underflow set; count becomes 1; r_valid=0 next cycle.
- No read-through: data written in cycle N is poppable from cycle N+1 at the earliest.
- Errors:
  - wr & ~wr_ok sets overflow; the data is dropped.
  - rd & empty sets underflow.
  - Both flags stay set until clear or reset.
- clear (synchronous, higher priority than rd/wr in the same cycle): w_ptr=r_ptr=0, count=0, r_valid=0, overflow=0, underflow=0; r_data holds its value. rd/wr in the clear cycle are ignored and do not set error flags.
- Wrap-around: pointers wrap naturally at DEPTH. Full/empty are determined solely by count, never by pointer equality.
- Reset mid-operation: all state returns to reset values asynchronously; in-flight reads produce no r_valid.
- Parameter legality: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH. Illegal combinations are flagged by an elaboration-time check.

Test Plan:
(Bench uses ADDR_WIDTH=3, DATA_WIDTH=24, AF_LEVEL=6, AE_LEVEL=2; DEPTH=8.)
1. Reset, then write 0x000001..0x000008 on 8 consecutive cycles -> count 1..8; almost_empty deasserts when count=3; almost_full asserts when count=6; full=1 at count=8; overflow=0.
2. Full FIFO, wr=1 with w_data=0xABCDEF, rd=0 -> data dropped, overflow=1 (sticky), count stays 8. Then read 8 entries -> r_data=0x000001..0x000008, each with r_valid one cycle after its rd, then empty=1.
3. Empty FIFO, rd=1 & wr=1 with w_data=0x123456 -> underflow=1, count=1, r_valid=0. Next cycle rd=1 -> following cycle r_data=0x123456, r_valid=1, empty=1.
4. Full FIFO, rd=1 & wr=1 with 0x0000AA -> oldest entry popped, full stays 1, count=8. Drain -> 0x0000AA emerges last.
5. Wrap: write 5 entries, read 5, then write 8 and read 8 -> order preserved across pointer wrap, no spurious flags.
6. FIFO with count=4 and overflow=1; assert clear with wr=1 -> count=0, empty=1, overflow=0, the write is ignored. Then assert reset mid-burst -> all outputs at reset values immediately, before the next clock edge.
